// File: rtl/ex_pkg.sv
// Shared definitions for the execute stage.
//   - ALU opcodes (4-bit aluop encoding)
//   - EX FSM state enum
//   - Packed control-bit bundle carried alongside each instruction
//   - Combinational ALU helper (everything except the iterative multiply)
package ex_pkg;

  localparam int unsigned MUL_STEPS = 8;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_AND  = 4'd2;
  localparam logic [3:0] OP_OR   = 4'd3;
  localparam logic [3:0] OP_XOR  = 4'd4;
  localparam logic [3:0] OP_NOT  = 4'd5;
  localparam logic [3:0] OP_SHL  = 4'd6;
  localparam logic [3:0] OP_SHR  = 4'd7;
  localparam logic [3:0] OP_MUL  = 4'd8;
  localparam logic [3:0] OP_PASS = 4'd9;
  localparam logic [3:0] OP_SLTU = 4'd10;

  typedef enum logic [0:0] {
    EX_IDLE,
    EX_BUSY
  } ex_state_e;

  // Bit order matches {Wr, Wm, Rm, Neq, J, JC}.
  typedef struct packed {
    logic wr;
    logic wm;
    logic rm;
    logic neq;
    logic j;
    logic jc;
  } ex_ctrl_t;

  // Single-cycle ALU. MUL and unassigned opcodes return 0; MUL results come
  // from the iterative multiplier instead.
  function automatic logic [7:0] alu_calc(input logic [3:0] op,
                                          input logic [7:0] a,
                                          input logic [7:0] b);
    logic [7:0] r;
    r = 8'h00;
    case (op)
      OP_ADD:  r = a + b;
      OP_SUB:  r = a - b;
      OP_AND:  r = a & b;
      OP_OR:   r = a | b;
      OP_XOR:  r = a ^ b;
      OP_NOT:  r = ~a;
      OP_SHL:  r = a << b[2:0];
      OP_SHR:  r = a >> b[2:0];
      OP_PASS: r = b;
      OP_SLTU: r = {7'b0, (a < b)};
      default: r = 8'h00;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/ex_mul8.sv
// Iterative shift-add multiplier, low WIDTH bits of a*b.
// Ports:
//   clock, reset   - rising-edge clock, async active-high reset
//   start          - latch a/b and begin (ignored while busy)
//   abort          - drop any in-progress multiply, return to idle
//   a, b           - operands, sampled on the start edge
//   busy           - a multiply is in progress
//   done           - combinational: the current edge performs the final step
//   product        - result of the current step; valid while done is high
module ex_mul8 import ex_pkg::*; #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned STEPS = MUL_STEPS
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] product
);

  localparam int unsigned CntW = $clog2(STEPS);

  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic [WIDTH-1:0] acc_step;

  always_comb begin
    acc_step = acc_q + (b_q[0] ? a_q : '0);
    a_d      = a_q;
    b_d      = b_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    busy_d   = busy_q;
    done     = busy_q && !abort && (cnt_q == CntW'(STEPS - 1));

    if (abort) begin
      busy_d = 1'b0;
      cnt_d  = '0;
      acc_d  = '0;
    end else if (busy_q) begin
      acc_d = acc_step;
      a_d   = a_q << 1;
      b_d   = b_q >> 1;
      cnt_d = cnt_q + 1'b1;
      if (done) begin
        busy_d = 1'b0;
        cnt_d  = '0;
      end
    end else if (start) begin
      a_d    = a;
      b_d    = b;
      acc_d  = '0;
      cnt_d  = '0;
      busy_d = 1'b1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      a_q    <= '0;
      b_q    <= '0;
      acc_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
    end else begin
      a_q    <= a_d;
      b_q    <= b_d;
      acc_q  <= acc_d;
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
    end
  end

  assign busy    = busy_q;
  // The last step's sum is forwarded directly so the product can be
  // registered into EX/MEM on the same edge that finishes the multiply.
  assign product = acc_step;

endmodule

// File: rtl/ex_stage.sv
// Execute stage: ALU, iterative multiply, and the EX/MEM pipeline register.
// Ports:
//   clock, reset             - rising-edge clock, async active-high reset
//   in_valid, aluop, opA/B   - decoded instruction and operands from ID/EX
//   store_val, rd_in, *_in   - pass-through store value, dest reg, control
//   pc_target                - branch/jump target, passed through
//   flush                    - squash current input and any in-flight MUL
//   stall                    - high while a MUL is iterating; decode holds
//   ex_valid .. PC           - registered EX/MEM outputs
module ex_stage #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned MUL_STEPS = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [3:0]       aluop,
  input  logic [WIDTH-1:0] opA,
  input  logic [WIDTH-1:0] opB,
  input  logic [WIDTH-1:0] store_val,
  input  logic [1:0]       rd_in,
  input  logic             Wr_in,
  input  logic             Wm_in,
  input  logic             Rm_in,
  input  logic             Neq_in,
  input  logic             J_in,
  input  logic             JC_in,
  input  logic [WIDTH-1:0] pc_target,
  input  logic             flush,
  output logic             stall,
  output logic             ex_valid,
  output logic [WIDTH-1:0] acOutValue,
  output logic             zeroOut,
  output logic [WIDTH-1:0] RegVal,
  output logic [1:0]       rdex,
  output logic             Wr,
  output logic             Wm,
  output logic             Rm,
  output logic             Neq,
  output logic             J,
  output logic             JC,
  output logic [WIDTH-1:0] PC
);

  import ex_pkg::*;

  ex_state_e        state_q, state_d;

  // EX/MEM register
  logic             vld_q, vld_d;
  logic [WIDTH-1:0] ac_q, ac_d;
  logic             zero_q, zero_d;
  logic [WIDTH-1:0] regval_q, regval_d;
  logic [1:0]       rd_q, rd_d;
  ex_ctrl_t         ctrl_q, ctrl_d;
  logic [WIDTH-1:0] pc_q, pc_d;

  // Fields captured at MUL accept, released with the product
  logic [WIDTH-1:0] lat_regval_q, lat_regval_d;
  logic [1:0]       lat_rd_q, lat_rd_d;
  ex_ctrl_t         lat_ctrl_q, lat_ctrl_d;
  logic [WIDTH-1:0] lat_pc_q, lat_pc_d;

  ex_ctrl_t         in_ctrl;
  logic [WIDTH-1:0] alu_res;
  logic             mul_start;
  logic             mul_abort;
  logic             mul_busy;
  logic             mul_done;
  logic [WIDTH-1:0] mul_product;

  assign in_ctrl = {Wr_in, Wm_in, Rm_in, Neq_in, J_in, JC_in};
  assign alu_res = alu_calc(aluop, opA, opB);

  ex_mul8 #(
    .WIDTH (WIDTH),
    .STEPS (MUL_STEPS)
  ) u_mul (
    .clock   (clock),
    .reset   (reset),
    .start   (mul_start),
    .abort   (mul_abort),
    .a       (opA),
    .b       (opB),
    .busy    (mul_busy),
    .done    (mul_done),
    .product (mul_product)
  );

  always_comb begin
    state_d      = state_q;
    // Default is a bubble: valid/control clear, data fields hold.
    vld_d        = 1'b0;
    ctrl_d       = '0;
    ac_d         = ac_q;
    zero_d       = zero_q;
    regval_d     = regval_q;
    rd_d         = rd_q;
    pc_d         = pc_q;
    lat_regval_d = lat_regval_q;
    lat_rd_d     = lat_rd_q;
    lat_ctrl_d   = lat_ctrl_q;
    lat_pc_d     = lat_pc_q;
    mul_start    = 1'b0;
    mul_abort    = 1'b0;

    if (flush) begin
      mul_abort = 1'b1;
      state_d   = EX_IDLE;
    end else begin
      case (state_q)
        EX_IDLE: begin
          if (in_valid) begin
            if (aluop == OP_MUL) begin
              mul_start    = 1'b1;
              lat_regval_d = store_val;
              lat_rd_d     = rd_in;
              lat_ctrl_d   = in_ctrl;
              lat_pc_d     = pc_target;
              state_d      = EX_BUSY;
            end else begin
              vld_d    = 1'b1;
              ac_d     = alu_res;
              zero_d   = ~|alu_res;
              regval_d = store_val;
              rd_d     = rd_in;
              ctrl_d   = in_ctrl;
              pc_d     = pc_target;
            end
          end
        end
        EX_BUSY: begin
          if (mul_done) begin
            vld_d    = 1'b1;
            ac_d     = mul_product;
            zero_d   = ~|mul_product;
            regval_d = lat_regval_q;
            rd_d     = lat_rd_q;
            ctrl_d   = lat_ctrl_q;
            pc_d     = lat_pc_q;
            state_d  = EX_IDLE;
          end
        end
        default: state_d = EX_IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= EX_IDLE;
      vld_q        <= 1'b0;
      ac_q         <= '0;
      zero_q       <= 1'b0;
      regval_q     <= '0;
      rd_q         <= '0;
      ctrl_q       <= '0;
      pc_q         <= '0;
      lat_regval_q <= '0;
      lat_rd_q     <= '0;
      lat_ctrl_q   <= '0;
      lat_pc_q     <= '0;
    end else begin
      state_q      <= state_d;
      vld_q        <= vld_d;
      ac_q         <= ac_d;
      zero_q       <= zero_d;
      regval_q     <= regval_d;
      rd_q         <= rd_d;
      ctrl_q       <= ctrl_d;
      pc_q         <= pc_d;
      lat_regval_q <= lat_regval_d;
      lat_rd_q     <= lat_rd_d;
      lat_ctrl_q   <= lat_ctrl_d;
      lat_pc_q     <= lat_pc_d;
    end
  end

  // The FSM and the multiplier track busy independently; they must agree.
  a_busy_match: assert property (@(posedge clock) disable iff (reset)
                                 (state_q == EX_BUSY) == mul_busy);

  assign stall      = (state_q == EX_BUSY);
  assign ex_valid   = vld_q;
  assign acOutValue = ac_q;
  assign zeroOut    = zero_q;
  assign RegVal     = regval_q;
  assign rdex       = rd_q;
  assign Wr         = ctrl_q.wr;
  assign Wm         = ctrl_q.wm;
  assign Rm         = ctrl_q.rm;
  assign Neq        = ctrl_q.neq;
  assign J          = ctrl_q.j;
  assign JC         = ctrl_q.jc;
  assign PC         = pc_q;

endmodule

// File: tb/tb_ex_stage.sv
// Scoreboard bench for ex_stage: stimulus pushes expected EX/MEM contents,
// a negedge monitor pops and compares whenever ex_valid is high.
module tb_ex_stage;

  typedef struct packed {
    logic [7:0] ac;
    logic       z;
    logic [7:0] rv;
    logic [1:0] rd;
    logic [5:0] ctrl;
    logic [7:0] pc;
  } exp_t;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       in_valid = 1'b0;
  logic [3:0] aluop = 4'd0;
  logic [7:0] opA = 8'd0, opB = 8'd0, store_val = 8'd0, pc_target = 8'd0;
  logic [1:0] rd_in = 2'd0;
  logic       Wr_in = 1'b0, Wm_in = 1'b0, Rm_in = 1'b0;
  logic       Neq_in = 1'b0, J_in = 1'b0, JC_in = 1'b0;
  logic       flush = 1'b0;
  logic       stall, ex_valid, zeroOut;
  logic [7:0] acOutValue, RegVal, PC;
  logic [1:0] rdex;
  logic       Wr, Wm, Rm, Neq, J, JC;

  int   n_checks = 0;
  int   n_errors = 0;
  exp_t exp_q[$];
  exp_t mon_exp, mon_got;

  ex_stage #(.WIDTH(8), .MUL_STEPS(8)) dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .aluop(aluop),
    .opA(opA), .opB(opB), .store_val(store_val), .rd_in(rd_in),
    .Wr_in(Wr_in), .Wm_in(Wm_in), .Rm_in(Rm_in), .Neq_in(Neq_in),
    .J_in(J_in), .JC_in(JC_in), .pc_target(pc_target), .flush(flush),
    .stall(stall), .ex_valid(ex_valid), .acOutValue(acOutValue),
    .zeroOut(zeroOut), .RegVal(RegVal), .rdex(rdex), .Wr(Wr), .Wm(Wm),
    .Rm(Rm), .Neq(Neq), .J(J), .JC(JC), .PC(PC)
  );

  always #5 clock = ~clock;

  // {op, a, b, expected result}
  logic [27:0] vecs [14] = '{
    28'h1050500,  // SUB 05-05 -> 00
    28'hA030401,  // SLTU 03<04 -> 01
    28'h6010902,  // SHL 01 by 9 (uses b[2:0]=1) -> 02
    28'h2F03C30,  // AND
    28'h3F00FFF,  // OR
    28'h4AAFF55,  // XOR
    28'h50F77F0,  // NOT a
    28'h7800F01,  // SHR 80 by 7
    28'h9123333,  // PASS b
    28'h0FF0100,  // ADD wraps -> 00
    28'hC556600,  // reserved op -> 00
    28'h10305FE,  // SUB wraps -> FE
    28'hA050300,  // SLTU 05<03 -> 00
    28'h6810102   // SHL 81 by 1 -> 02
  };

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                       input logic [7:0] sv, input logic [1:0] rd, input logic [5:0] ctrl,
                       input logic [7:0] pc);
    in_valid  = 1'b1;
    aluop     = op;
    opA       = a;
    opB       = b;
    store_val = sv;
    rd_in     = rd;
    {Wr_in, Wm_in, Rm_in, Neq_in, J_in, JC_in} = ctrl;
    pc_target = pc;
  endtask

  task automatic push_exp(input logic [7:0] ac, input logic [7:0] sv, input logic [1:0] rd,
                          input logic [5:0] ctrl, input logic [7:0] pc);
    exp_t e;
    e.ac = ac; e.z = (ac == 8'h00); e.rv = sv; e.rd = rd; e.ctrl = ctrl; e.pc = pc;
    exp_q.push_back(e);
  endtask

  // Monitor: every valid EX/MEM output must match the oldest expectation.
  always @(negedge clock) begin
    if (!reset && ex_valid) begin
      n_checks++;
      mon_got = {acOutValue, zeroOut, RegVal, rdex, Wr, Wm, Rm, Neq, J, JC, PC};
      if (exp_q.size() == 0) begin
        n_errors++;
        $display("FAIL unexpected_output: got %0h, expected no valid output", mon_got);
      end else begin
        mon_exp = exp_q.pop_front();
        if (mon_got !== mon_exp) begin
          n_errors++;
          $display("FAIL exmem_fields: got %0h, expected %0h", mon_got, mon_exp);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [27:0] v;
    int          n;

    // Reset state
    #3;
    check("reset_outputs",
          {ex_valid, acOutValue, zeroOut, RegVal, rdex, Wr, Wm, Rm, Neq, J, JC, PC, stall},
          64'd0);
    tick(); tick();
    reset = 1'b0;

    // ADD 7F+01, rd=2, Wr=1
    drive(ex_pkg::OP_ADD, 8'h7F, 8'h01, 8'h11, 2'd2, 6'b100000, 8'h21);
    push_exp(8'h80, 8'h11, 2'd2, 6'b100000, 8'h21);
    check("add_no_stall_before", {63'd0, stall}, 64'd0);
    tick();
    check("add_no_stall_after", {63'd0, stall}, 64'd0);
    check("add_latency", {63'd0, ex_valid}, 64'd1);

    // Directed ALU table, back to back
    for (int i = 0; i < 14; i++) begin
      v = vecs[i];
      drive(v[27:24], v[23:16], v[15:8], 8'(i * 7), 2'(i), 6'(i), 8'(8'h80 + i));
      push_exp(v[7:0], 8'(i * 7), 2'(i), 6'(i), 8'(8'h80 + i));
      tick();
    end
    in_valid = 1'b0;
    check("table_no_stall", {63'd0, stall}, 64'd0);
    tick();

    // MUL 13x11 with Rm, followed by an ADD held at the input
    drive(ex_pkg::OP_MUL, 8'h0D, 8'h0B, 8'h5A, 2'd1, 6'b001000, 8'h30);
    push_exp(8'h8F, 8'h5A, 2'd1, 6'b001000, 8'h30);
    tick();
    drive(ex_pkg::OP_ADD, 8'h10, 8'h20, 8'h66, 2'd3, 6'b100000, 8'h40);
    push_exp(8'h30, 8'h66, 2'd3, 6'b100000, 8'h40);
    for (int i = 0; i < 8; i++) begin
      check($sformatf("mul_stall_%0d", i), {63'd0, stall}, 64'd1);
      check($sformatf("mul_bubble_%0d", i), {63'd0, ex_valid}, 64'd0);
      tick();
    end
    check("mul_stall_drop", {63'd0, stall}, 64'd0);
    check("mul_result_valid", {63'd0, ex_valid}, 64'd1);
    tick();
    in_valid = 1'b0;
    check("held_add_valid", {63'd0, ex_valid}, 64'd1);
    tick();
    check("held_add_once", {63'd0, ex_valid}, 64'd0);

    // MUL 20x10 -> 00 (zero), then MUL FF*FF -> 01 back to back
    drive(ex_pkg::OP_MUL, 8'h20, 8'h10, 8'h00, 2'd0, 6'b100000, 8'h00);
    push_exp(8'h00, 8'h00, 2'd0, 6'b100000, 8'h00);
    tick();
    drive(ex_pkg::OP_MUL, 8'hFF, 8'hFF, 8'h77, 2'd2, 6'b100000, 8'h12);
    push_exp(8'h01, 8'h77, 2'd2, 6'b100000, 8'h12);
    repeat (8) tick();
    check("b2b_first_done", {62'd0, stall, ex_valid}, 64'b01);
    tick();
    in_valid = 1'b0;
    check("b2b_second_accept", {62'd0, stall, ex_valid}, 64'b10);
    n = 0;
    while (stall && n < 20) begin
      tick();
      n++;
    end
    check("b2b_stall_cycles", 64'(n), 64'd8);
    tick();

    // Flush while BUSY at count 3
    drive(ex_pkg::OP_MUL, 8'h07, 8'h09, 8'h00, 2'd1, 6'b100000, 8'h00);
    tick();
    in_valid = 1'b0;
    repeat (3) tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("flush_busy", {62'd0, stall, ex_valid}, 64'd0);
    repeat (12) tick();
    check("flush_busy_idle", {63'd0, stall}, 64'd0);

    // Flush coincident with a valid ADD
    drive(ex_pkg::OP_ADD, 8'h01, 8'h01, 8'h00, 2'd1, 6'b100000, 8'h00);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    in_valid = 1'b0;
    check("flush_add_bubble", {62'd0, ex_valid, Wr}, 64'd0);
    tick();
    check("flush_add_dropped", {63'd0, ex_valid}, 64'd0);

    // Load non-zero fields, then async reset at MUL count 5
    drive(ex_pkg::OP_ADD, 8'h10, 8'h22, 8'h9C, 2'd3, 6'b110011, 8'h44);
    push_exp(8'h32, 8'h9C, 2'd3, 6'b110011, 8'h44);
    tick();
    drive(ex_pkg::OP_MUL, 8'h03, 8'h05, 8'h01, 2'd1, 6'b100000, 8'h01);
    tick();
    in_valid = 1'b0;
    repeat (5) tick();
    #2;
    reset = 1'b1;
    #1;
    check("reset_mid_mul",
          {ex_valid, acOutValue, zeroOut, RegVal, rdex, Wr, Wm, Rm, Neq, J, JC, PC, stall},
          64'd0);
    tick();
    reset = 1'b0;

    // ADD 1+1 after reset, one-edge latency
    drive(ex_pkg::OP_ADD, 8'h01, 8'h01, 8'h00, 2'd1, 6'b100000, 8'h02);
    push_exp(8'h02, 8'h00, 2'd1, 6'b100000, 8'h02);
    tick();
    in_valid = 1'b0;
    check("post_reset_add", {55'd0, ex_valid, acOutValue}, {55'd0, 1'b1, 8'h02});
    tick(); tick();

    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
